out_acc_wb: RTL and testbench
=============================

# out_acc_wb

Read-modify-write accumulation stage that sits directly upstream of the output memory. It accepts Winograd output-transform tiles (512 bits = 32 lanes of signed 16-bit), reads the current partial sum from output memory port 1, adds lane-wise, and writes the result back through port 2. It counts completed write-backs against a programmed tile count and reports done, so the controller knows when to scan out.

## Interface
- `LANES`, 32, number of 16-bit lanes per 512-bit word.
- `AW`, 8, address width. Only bits [6:0] are meaningful to output memory; bit 7 is passed through.
- `CNT_W`, 16, width of the tile counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; loads `num_tiles` and enters RUN.
- `num_tiles`  in  CNT_W  number of write-backs expected in this pass. 0 is legal.
- `in_valid`  in  1  tile is presented.
- `in_ready`  out  1  tile accepted when `in_valid && in_ready` at a rising edge.
- `in_addr`  in  AW  target output-memory word.
- `in_first`  in  1  first input channel; overwrite instead of accumulate.
- `in_data`  in  512  tile, lane i = bits [16i+15:16i].
- `mem_rd_valid`  out  1  read request on port 1 (drives `package_1_valid_in`).
- `mem_rd_addr`  out  AW  read address (drives `addr_1_in`).
- `mem_rd_data`  in  512  port-1 read data, valid the cycle after the request.
- `mem_wr_valid`  out  1  write request on port 2 (drives `package_2_valid_in`).
- `mem_wr_addr`  out  AW  write address.
- `mem_wr_data`  out  512  write data.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  high in DONE.
- `wr_count`  out  CNT_W  write-backs completed in this pass.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - RUN: on `start`, go to RUN; `wr_count` := 0; latch `num_tiles`. If `num_tiles`==0, go straight to DONE.
  - DRAIN: in RUN, when the accepted count reaches the latched `num_tiles`, go to DRAIN; `in_ready`=0.
  - DONE: DRAIN goes to DONE when stages A, B and W are all empty and `wr_count`==latched `num_tiles`. DONE holds until the next `start`, which restarts RUN.
  - A `start` received in RUN or DRAIN is ignored.
- Pipeline, three registered stages, each with a valid bit and addr/first/data:
  - A: issues the read. `mem_rd_valid`=A.valid, `mem_rd_addr`=A.addr.
  - B: captures `mem_rd_data` and forms the result. Lane i = in lane i if first, else in lane i + mem lane i.
  - W: drives `mem_wr_*` from registered values.
- Stages advance every cycle. There is no downstream backpressure, because output memory always accepts.
- Hazard rule:
  - `in_ready` = (state==RUN) && !(A.valid && A.addr==in_addr) && !(B.valid && B.addr==in_addr) && !(W.valid && W.addr==in_addr).
  - This guarantees a read never precedes an in-flight write to the same address.
- A read is issued even when `in_first`=1; its data is ignored.
- Lane arithmetic is signed 16-bit; overflow handling is set in Configuration. Lanes are independent, with no carry between lanes.
- `wr_count` increments by 1 in each cycle that `mem_wr_valid`=1.
- Reset mid-operation: all stage valid bits clear and in-flight tiles are dropped. No partial write reaches memory after reset asserts.

## Timing
- Reset values: `in_ready`=0, `mem_rd_valid`=0, `mem_wr_valid`=0, all addr/data outputs 0, `busy`=0, `done`=0, `wr_count`=0, state IDLE.
- Latency: a tile accepted at edge N is in A during cycle N+1 (read issued) and in B during N+2. `mem_wr_valid` is high during N+3.
- Throughput: 1 tile/cycle to distinct addresses.
- Back-to-back tiles to the same address: the second is accepted no earlier than the edge that ends the first tile's W cycle. That is 3 stall cycles, so its read sees the written value.
- `done` rises the cycle after the last `mem_wr_valid` cycle.

## Configuration
- `OUT_ACC_SAT_EN` defined: each lane add saturates to [-32768, 32767].
- `OUT_ACC_SAT_EN` undefined: each lane add wraps modulo 2^16.
- `in_first` overwrite is unaffected in both modes.

## Test plan
- Reset/idle: hold `rst_n`=0, then release. All outputs are at reset values, and `in_ready`=0 until `start`.
- Basic first pass: `start` with `num_tiles`=4; 4 tiles to addrs 0–3, `in_first`=1, lane values = addr. Writes appear 3 cycles after each accept with data equal to the input; `wr_count`=4, then `done`=1.
- Accumulate:
  - Memory model holds 0x0010 in all lanes at addr 5.
  - Send a tile with `in_first`=0 and lanes 0x0003 to addr 5.
  - Required: the write to addr 5 carries 0x0013 in all lanes.
- Hazard stall: two consecutive tiles to addr 7, each lanes=1, first=0, memory initially 0. Required: `in_ready` is low for 3 cycles after the first accept; the final write is 2 per lane.
- Overflow: memory holds 0x7FFF at addr 9, add 1.
  - With `OUT_ACC_SAT_EN`, the written value is 0x7FFF.
  - Without it, the written value is 0x8000.
- Reset mid-pass: assert `rst_n` low while A and B are valid. No `mem_wr_valid` occurs afterwards, and state is IDLE; a `start` with `num_tiles`=0 reaches `done` the next cycle.

Source files
------------

// File: rtl/out_acc_wb.sv
// Read-modify-write accumulator in front of output memory: read (A), add (B), write back (W).
// Define OUT_ACC_SAT_EN for saturating lane adds; otherwise lanes wrap modulo 2^16.
module out_acc_wb #(
    parameter int unsigned LANES = 32,
    parameter int unsigned AW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_tiles,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_addr,
    input  logic                in_first,
    input  logic [LANES*16-1:0] in_data,
    output logic                mem_rd_valid,
    output logic [AW-1:0]       mem_rd_addr,
    input  logic [LANES*16-1:0] mem_rd_data,
    output logic                mem_wr_valid,
    output logic [AW-1:0]       mem_wr_addr,
    output logic [LANES*16-1:0] mem_wr_data,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    wr_count
);

    localparam int unsigned DW = LANES * 16;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic          a_v_q, a_v_d, a_first_q, a_first_d;
    logic [AW-1:0] a_addr_q, a_addr_d;
    logic [DW-1:0] a_data_q, a_data_d;
    logic          b_v_q, b_v_d, b_first_q, b_first_d;
    logic [AW-1:0] b_addr_q, b_addr_d;
    logic [DW-1:0] b_data_q, b_data_d;
    logic          w_v_q, w_v_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0] w_data_q, w_data_d;

    logic          accept;
    logic [DW-1:0] sum;

    function automatic logic [15:0] lane_add(input logic [15:0] a, input logic [15:0] b);
`ifdef OUT_ACC_SAT_EN
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        // Sign bits disagree only on signed overflow; clamp toward the overflow direction.
        if (s[16] != s[15]) lane_add = s[16] ? 16'h8000 : 16'h7fff;
        else                lane_add = s[15:0];
`else
        lane_add = a + b;
`endif
    endfunction

    // Hold off any tile whose address is still in flight so its read sees the written value.
    always_comb begin
        in_ready = (state_q == StRun)
                   && !(a_v_q && (a_addr_q == in_addr))
                   && !(b_v_q && (b_addr_q == in_addr))
                   && !(w_v_q && (w_addr_q == in_addr));
        accept   = in_valid && in_ready;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum[16*i +: 16] = b_first_q ? b_data_q[16*i +: 16]
                                        : lane_add(b_data_q[16*i +: 16], mem_rd_data[16*i +: 16]);
        end
    end

    always_comb begin
        a_v_d     = accept;
        a_addr_d  = accept ? in_addr  : a_addr_q;
        a_first_d = accept ? in_first : a_first_q;
        a_data_d  = accept ? in_data  : a_data_q;
        b_v_d     = a_v_q;
        b_addr_d  = a_v_q ? a_addr_q  : b_addr_q;
        b_first_d = a_v_q ? a_first_q : b_first_q;
        b_data_d  = a_v_q ? a_data_q  : b_data_q;
        w_v_d     = b_v_q;
        w_addr_d  = b_v_q ? b_addr_q : w_addr_q;
        w_data_d  = b_v_q ? sum      : w_data_q;
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        acc_d    = acc_q;
        wr_cnt_d = w_v_q ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d    = num_tiles;
                    acc_d    = '0;
                    wr_cnt_d = '0;
                    state_d  = (num_tiles == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_d == num_q) state_d = StDrain;
                end
            end
            StDrain: begin
                // Look at next-cycle occupancy so done rises right after the last write.
                if (!a_v_q && !b_v_q && (wr_cnt_d == num_q)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            num_q     <= '0;
            acc_q     <= '0;
            wr_cnt_q  <= '0;
            a_v_q     <= 1'b0;
            a_addr_q  <= '0;
            a_first_q <= 1'b0;
            a_data_q  <= '0;
            b_v_q     <= 1'b0;
            b_addr_q  <= '0;
            b_first_q <= 1'b0;
            b_data_q  <= '0;
            w_v_q     <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            acc_q     <= acc_d;
            wr_cnt_q  <= wr_cnt_d;
            a_v_q     <= a_v_d;
            a_addr_q  <= a_addr_d;
            a_first_q <= a_first_d;
            a_data_q  <= a_data_d;
            b_v_q     <= b_v_d;
            b_addr_q  <= b_addr_d;
            b_first_q <= b_first_d;
            b_data_q  <= b_data_d;
            w_v_q     <= w_v_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
        end
    end

    assign mem_rd_valid = a_v_q;
    assign mem_rd_addr  = a_addr_q;
    assign mem_wr_valid = w_v_q;
    assign mem_wr_addr  = w_addr_q;
    assign mem_wr_data  = w_data_q;
    assign busy         = (state_q == StRun) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_out_acc_wb.sv
// Directed + randomized bench for out_acc_wb against a word-level accumulate model and
// a behavioural output memory; honours OUT_ACC_SAT_EN for the overflow expectation.
module tb_out_acc_wb;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   num_tiles = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_addr = '0;
    logic          in_first = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          mem_rd_valid;
    logic [7:0]    mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_valid;
    logic [7:0]    mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          busy;
    logic          done;
    logic [15:0]   wr_count;

    out_acc_wb dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_first(in_first), .in_data(in_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = -100;

    // Behavioural output memory: 1-cycle read latency, write on the edge.
    bit [DW-1:0] mem [256];
    bit [DW-1:0] shadow [256];
    bit [DW-1:0] rd_q;
    logic          poke_en = 1'b0;
    logic [7:0]    poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_valid) rd_q <= mem[mem_rd_addr];
        if (mem_wr_valid) mem[mem_wr_addr] <= mem_wr_data;
        if (poke_en) mem[poke_addr] <= poke_data;
    end
    assign mem_rd_data = rd_q;

    typedef struct {
        logic [7:0]    addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef OUT_ACC_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && mem_wr_valid) begin
            chk("write_expected", DW'(exp_q.size() != 0), DW'(1));
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", DW'(mem_wr_addr), DW'(e.addr));
                chk("wr_data", mem_wr_data, e.data);
                chk("wr_latency", DW'(cyc), DW'(e.cyc));
            end
            last_wr_cyc = cyc;
        end
    end

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        shadow[a] = d;
    endtask

    task automatic start_pass(input int n);
        start = 1'b1; num_tiles = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic f, input logic [DW-1:0] d,
                        output int stall);
        exp_t e;
        in_valid = 1'b1; in_addr = a; in_first = f; in_data = d;
        stall = 0;
        @(negedge clk);
        while (!in_ready && stall < 50) begin
            stall++;
            @(negedge clk);
        end
        chk("accept", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (stall < 50) begin
            e.addr = a;
            e.cyc  = cyc + 2;
            for (int i = 0; i < 32; i++)
                e.data[16*i +: 16] = f ? d[16*i +: 16] : ref_add(shadow[a][16*i +: 16], d[16*i +: 16]);
            shadow[a] = e.data;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        @(negedge clk);
        while (!done && k < 60) begin
            k++;
            @(negedge clk);
        end
        chk("done", DW'(done), DW'(1));
        chk("done_timing", DW'(cyc), DW'(last_wr_cyc + 1));
        chk("wr_count", DW'(wr_count), DW'(n));
        chk("busy_clear", DW'(busy), DW'(0));
        chk("queue_drained", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        int st, st2;
        logic [DW-1:0] d;
        logic [7:0] a;

        // Reset / idle
        in_valid = 1'b1; in_addr = 8'h05;
        @(negedge clk);
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_rd_valid", DW'(mem_rd_valid), DW'(0));
        chk("rst_wr_valid", DW'(mem_wr_valid), DW'(0));
        chk("rst_rd_addr", DW'(mem_rd_addr), DW'(0));
        chk("rst_wr_addr", DW'(mem_wr_addr), DW'(0));
        chk("rst_wr_data", mem_wr_data, '0);
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_wr_count", DW'(wr_count), DW'(0));
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", DW'(in_ready), DW'(0));
            chk("idle_busy", DW'(busy), DW'(0));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Basic first pass: lanes = addr, overwrite, back-to-back distinct addresses
        start_pass(4);
        chk("run_busy", DW'(busy), DW'(1));
        chk("run_wr_count0", DW'(wr_count), DW'(0));
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) d[16*i +: 16] = 16'(k);
            send(8'(k), 1'b1, d, st);
            chk("throughput_stall", DW'(st), DW'(0));
        end
        wait_done(4);

        // Accumulate
        poke(8'd5, {32{16'h0010}});
        start_pass(1);
        send(8'd5, 1'b0, {32{16'h0003}}, st);
        wait_done(1);
        chk("accum_mem", mem[5], {32{16'h0013}});

        // Hazard: same address back to back
        start_pass(2);
        send(8'd7, 1'b0, {32{16'h0001}}, st);
        send(8'd7, 1'b0, {32{16'h0001}}, st2);
        chk("hazard_stall", DW'(st2), DW'(3));
        wait_done(2);
        chk("hazard_mem", mem[7], {32{16'h0002}});

        // Overflow
        poke(8'd9, {32{16'h7fff}});
        start_pass(1);
        send(8'd9, 1'b0, {32{16'h0001}}, st);
        wait_done(1);
`ifdef OUT_ACC_SAT_EN
        chk("overflow_mem", mem[9], {32{16'h7fff}});
`else
        chk("overflow_mem", mem[9], {32{16'h8000}});
`endif

        // Randomized pass on a small address set to provoke hazards
        start_pass(24);
        for (int k = 0; k < 24; k++) begin
            a = {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))};
            for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
            send(a, ($urandom_range(0, 3) == 0), d, st);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        wait_done(24);

        // Reset mid-pass with A and B occupied
        start_pass(4);
        send(8'h20, 1'b0, {32{16'h0004}}, st);
        send(8'h21, 1'b0, {32{16'h0004}}, st);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_rd_valid", DW'(mem_rd_valid), DW'(0));
        chk("midrst_wr_valid", DW'(mem_wr_valid), DW'(0));
        chk("midrst_busy", DW'(busy), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_addr = 8'h22;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_in_ready", DW'(in_ready), DW'(0));
            chk("post_rst_busy", DW'(busy), DW'(0));
            chk("post_rst_done", DW'(done), DW'(0));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        start_pass(0);
        chk("zero_done", DW'(done), DW'(1));
        chk("zero_wr_count", DW'(wr_count), DW'(0));
        chk("zero_busy", DW'(busy), DW'(0));
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
